// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer
// Frame-paced game flow controller for the racing game.
// Sequence: IDLE -> COUNTDOWN -> RUN -> (DYING -> COUNTDOWN)* -> GAME_OVER / WIN -> IDLE.
// All state changes happen on frame_start cycles. Crash and finish events may
// arrive on any cycle; they are latched until the next frame_start consumes them.
//
// Ports
//   clk             system clock
//   resetN          asynchronous active-low reset
//   frame_start     one-cycle pulse per video frame
//   start_pressed   start key level
//   crash           collision event (pulse or level)
//   finish_reached  finish-line event (pulse or level)
//   phase           0 IDLE, 1 COUNTDOWN, 2 RUN, 3 DYING, 4 GAME_OVER, 5 WIN
//   enable_motion   high only while in RUN
//   death_start     one-cycle pulse on the cycle that enters DYING
//   lives           remaining lives
//   fuel            remaining fuel
module game_flow_sequencer #(
   parameter int LIVES_INIT      = 3,
   parameter int FUEL_INIT       = 100,
   parameter int FUEL_DEC_FRAMES = 60,
   parameter int DEATH_FRAMES    = 193,
   parameter int COUNT_FRAMES    = 120
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       frame_start,
   input  logic       start_pressed,
   input  logic       crash,
   input  logic       finish_reached,
   output logic [2:0] phase,
   output logic       enable_motion,
   output logic       death_start,
   output logic [1:0] lives,
   output logic [6:0] fuel
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_RUN       = 3'd2,
      S_DYING     = 3'd3,
      S_GAME_OVER = 3'd4,
      S_WIN       = 3'd5
   } state_t;

   localparam logic [1:0]  LIVES_INIT_V   = 2'(LIVES_INIT);
   localparam logic [6:0]  FUEL_INIT_V    = 7'(FUEL_INIT);
   localparam logic [15:0] COUNT_LAST     = 16'(COUNT_FRAMES - 1);
   localparam logic [15:0] DEATH_LAST     = 16'(DEATH_FRAMES - 1);
   localparam logic [15:0] FUEL_DEC_LAST  = 16'(FUEL_DEC_FRAMES - 1);

   state_t      state_reg, state_next;
   logic [15:0] frame_cnt_reg, frame_cnt_next;
   logic [15:0] fuel_cnt_reg, fuel_cnt_next;
   logic [1:0]  lives_reg, lives_next;
   logic [6:0]  fuel_reg, fuel_next;
   logic        crash_l_reg, crash_l_next;
   logic        finish_l_reg, finish_l_next;
   logic        released_reg, released_next;
   logic        death_start_reg, death_start_next;
   logic        crash_evt, finish_evt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg       <= S_IDLE;
         frame_cnt_reg   <= '0;
         fuel_cnt_reg    <= '0;
         lives_reg       <= LIVES_INIT_V;
         fuel_reg        <= FUEL_INIT_V;
         crash_l_reg     <= 1'b0;
         finish_l_reg    <= 1'b0;
         released_reg    <= 1'b0;
         death_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         frame_cnt_reg   <= frame_cnt_next;
         fuel_cnt_reg    <= fuel_cnt_next;
         lives_reg       <= lives_next;
         fuel_reg        <= fuel_next;
         crash_l_reg     <= crash_l_next;
         finish_l_reg    <= finish_l_next;
         released_reg    <= released_next;
         death_start_reg <= death_start_next;
      end
   end

   always_comb begin
      // An event arriving on the consuming frame_start cycle still counts.
      crash_evt        = crash_l_reg | crash;
      finish_evt       = finish_l_reg | finish_reached;
      state_next       = state_reg;
      lives_next       = lives_reg;
      fuel_next        = fuel_reg;
      fuel_cnt_next    = fuel_cnt_reg;
      released_next    = released_reg;
      death_start_next = 1'b0;
      frame_cnt_next   = frame_cnt_reg;
      // Every frame_start consumes the latched events; only RUN acts on them.
      crash_l_next     = frame_start ? 1'b0 : crash_evt;
      finish_l_next    = frame_start ? 1'b0 : finish_evt;

      case (state_reg)
         S_IDLE: begin
            if (frame_start && start_pressed) begin
               state_next    = S_COUNTDOWN;
               lives_next    = LIVES_INIT_V;
               fuel_next     = FUEL_INIT_V;
               fuel_cnt_next = '0;
            end
         end
         S_COUNTDOWN: begin
            if (frame_start && frame_cnt_reg == COUNT_LAST)
               state_next = S_RUN;
         end
         S_RUN: begin
            if (frame_start) begin
               if (crash_evt) begin
                  state_next       = S_DYING;
                  death_start_next = 1'b1;
                  lives_next       = (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
               end else if (finish_evt) begin
                  state_next = S_WIN;
               end else if (fuel_reg == 7'd0) begin
                  state_next = S_GAME_OVER;
               end else if (fuel_cnt_reg == FUEL_DEC_LAST) begin
                  // fuel_reg is nonzero here, so the decrement cannot wrap.
                  fuel_next     = fuel_reg - 7'd1;
                  fuel_cnt_next = '0;
               end else begin
                  fuel_cnt_next = fuel_cnt_reg + 16'd1;
               end
            end
         end
         S_DYING: begin
            if (frame_start && frame_cnt_reg == DEATH_LAST)
               state_next = (lives_reg != 2'd0) ? S_COUNTDOWN : S_GAME_OVER;
         end
         S_GAME_OVER, S_WIN: begin
            // Leave only after the key has been seen released, so a key still
            // held from gameplay does not skip this screen.
            if (frame_start) begin
               if (start_pressed && released_reg)
                  state_next = S_IDLE;
               else if (!start_pressed)
                  released_next = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase

      if (state_next != state_reg) begin
         frame_cnt_next = '0;
         released_next  = 1'b0;
      end else if (frame_start) begin
         frame_cnt_next = frame_cnt_reg + 16'd1;
      end
   end

   assign phase         = state_reg;
   assign enable_motion = (state_reg == S_RUN);
   assign death_start   = death_start_reg;
   assign lives         = lives_reg;
   assign fuel          = fuel_reg;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Testbench for game_flow_sequencer. One instance runs default parameters for
// the game flow; a second instance with a tiny fuel budget checks fuel exhaustion.
module tb_game_flow_sequencer;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       frame_start = 1'b0;
   logic       start_pressed = 1'b0;
   logic       crash = 1'b0;
   logic       finish_reached = 1'b0;
   logic [2:0] phase, phase_f;
   logic       enable_motion, enable_motion_f;
   logic       death_start, death_start_f;
   logic [1:0] lives, lives_f;
   logic [6:0] fuel, fuel_f;

   int errors = 0;
   int checks = 0;
   int ds_pulses = 0;

   always #5 clk = ~clk;

   game_flow_sequencer dut (
      .clk(clk), .resetN(resetN), .frame_start(frame_start),
      .start_pressed(start_pressed), .crash(crash), .finish_reached(finish_reached),
      .phase(phase), .enable_motion(enable_motion), .death_start(death_start),
      .lives(lives), .fuel(fuel)
   );

   game_flow_sequencer #(.FUEL_INIT(2), .FUEL_DEC_FRAMES(4)) dut_f (
      .clk(clk), .resetN(resetN), .frame_start(frame_start),
      .start_pressed(start_pressed), .crash(crash), .finish_reached(finish_reached),
      .phase(phase_f), .enable_motion(enable_motion_f), .death_start(death_start_f),
      .lives(lives_f), .fuel(fuel_f)
   );

   always @(negedge clk) if (death_start) ds_pulses++;

   typedef struct {
      logic       st;
      logic       cr;
      logic       fi;
      logic       same;   // event on the frame_start cycle instead of mid-frame
      int         n;      // frames to apply; the event goes on the last one
      logic [2:0] ph;
      logic [1:0] lv;
      logic [6:0] fu;
      logic       em;
      logic       ds;
   } vec_t;

   vec_t vecs[28];

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // One frame = 4 clocks; inputs change on negedge, frame_start in the 3rd clock.
   task automatic do_frame(input logic st, input logic cr, input logic fi, input logic same);
      @(negedge clk);
      start_pressed = st;
      crash = cr & ~same;
      finish_reached = fi & ~same;
      @(negedge clk);
      crash = 1'b0;
      finish_reached = 1'b0;
      @(negedge clk);
      frame_start = 1'b1;
      crash = cr & same;
      finish_reached = fi & same;
      @(negedge clk);
      frame_start = 1'b0;
      crash = 1'b0;
      finish_reached = 1'b0;
   endtask

   task automatic run_frames(input int n, input logic st);
      for (int k = 0; k < n; k++) do_frame(st, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0;
      start_pressed = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      //           st cr fi sm  n    ph lv fu   em ds
      vecs[0]  = '{0, 0, 0, 0, 2,   0, 3, 100, 0, 0};
      vecs[1]  = '{1, 0, 0, 0, 1,   1, 3, 100, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 119, 1, 3, 100, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 1,   2, 3, 100, 1, 0};
      vecs[4]  = '{0, 0, 0, 0, 10,  2, 3, 100, 1, 0};
      vecs[5]  = '{0, 1, 0, 0, 1,   3, 2, 100, 0, 1};
      vecs[6]  = '{0, 0, 0, 0, 192, 3, 2, 100, 0, 0};
      vecs[7]  = '{0, 0, 0, 0, 1,   1, 2, 100, 0, 0};
      vecs[8]  = '{0, 1, 0, 0, 1,   1, 2, 100, 0, 0};
      vecs[9]  = '{0, 0, 0, 0, 118, 1, 2, 100, 0, 0};
      vecs[10] = '{0, 1, 0, 1, 1,   2, 2, 100, 1, 0};
      vecs[11] = '{0, 0, 0, 0, 49,  2, 2, 100, 1, 0};
      vecs[12] = '{0, 0, 0, 0, 1,   2, 2, 99,  1, 0};
      vecs[13] = '{0, 1, 1, 0, 1,   3, 1, 99,  0, 1};
      vecs[14] = '{0, 0, 0, 0, 193, 1, 1, 99,  0, 0};
      vecs[15] = '{0, 0, 0, 0, 120, 2, 1, 99,  1, 0};
      vecs[16] = '{0, 1, 0, 1, 1,   3, 0, 99,  0, 1};
      vecs[17] = '{0, 0, 0, 0, 192, 3, 0, 99,  0, 0};
      vecs[18] = '{1, 0, 0, 0, 1,   4, 0, 99,  0, 0};
      vecs[19] = '{1, 0, 0, 0, 3,   4, 0, 99,  0, 0};
      vecs[20] = '{0, 0, 0, 0, 1,   4, 0, 99,  0, 0};
      vecs[21] = '{1, 0, 0, 0, 1,   0, 0, 99,  0, 0};
      vecs[22] = '{1, 0, 0, 0, 1,   1, 3, 100, 0, 0};
      vecs[23] = '{0, 0, 0, 0, 120, 2, 3, 100, 1, 0};
      vecs[24] = '{1, 0, 1, 0, 1,   5, 3, 100, 0, 0};
      vecs[25] = '{1, 0, 0, 0, 2,   5, 3, 100, 0, 0};
      vecs[26] = '{0, 0, 0, 0, 1,   5, 3, 100, 0, 0};
      vecs[27] = '{1, 0, 0, 0, 1,   0, 3, 100, 0, 0};

      // Reset state, checked while reset is still asserted.
      #12;
      check("rst.phase", phase, 0);
      check("rst.lives", lives, 3);
      check("rst.fuel", fuel, 100);
      check("rst.em", enable_motion, 0);
      check("rst.ds", death_start, 0);
      do_reset();

      for (int i = 0; i < 28; i++) begin
         for (int k = 0; k < vecs[i].n; k++)
            do_frame(vecs[i].st,
                     (k == vecs[i].n - 1) ? vecs[i].cr : 1'b0,
                     (k == vecs[i].n - 1) ? vecs[i].fi : 1'b0,
                     vecs[i].same);
         check($sformatf("v%0d.phase", i), phase, vecs[i].ph);
         check($sformatf("v%0d.lives", i), lives, vecs[i].lv);
         check($sformatf("v%0d.fuel", i), fuel, vecs[i].fu);
         check($sformatf("v%0d.em", i), enable_motion, vecs[i].em);
         check($sformatf("v%0d.ds", i), death_start, vecs[i].ds);
         $display("vec %0d: frames=%0d phase=%0d lives=%0d fuel=%0d em=%0b ds=%0b",
                  i, vecs[i].n, phase, lives, fuel, enable_motion, death_start);
      end

      // death_start lasts exactly one cycle.
      do_reset();
      do_frame(1, 0, 0, 0);
      run_frames(120, 0);
      do_frame(0, 1, 0, 0);
      check("pulse.high", death_start, 1);
      @(negedge clk);
      check("pulse.low", death_start, 0);

      // Reset in the middle of DYING aborts at once and no pulse follows.
      run_frames(50, 0);
      check("abort.pre_phase", phase, 3);
      #2 resetN = 1'b0;
      #1;
      check("abort.phase", phase, 0);
      check("abort.lives", lives, 3);
      check("abort.fuel", fuel, 100);
      check("abort.em", enable_motion, 0);
      @(negedge clk);
      resetN = 1'b1;
      ds_pulses = 0;
      run_frames(200, 0);
      check("abort.no_ds", ds_pulses, 0);
      check("abort.idle", phase, 0);
      do_frame(1, 0, 0, 0);
      check("abort.first_start", phase, 1);
      $display("reset abort: phase=%0d lives=%0d ds_pulses=%0d", phase, lives, ds_pulses);

      // Fuel exhaustion on the small-fuel instance.
      do_reset();
      do_frame(1, 0, 0, 0);
      run_frames(120, 0);
      check("fuel.run", phase_f, 2);
      check("fuel.init", fuel_f, 2);
      for (int k = 1; k <= 10; k++) begin
         do_frame(0, 0, 0, 0);
         check($sformatf("fuel.f%0d.fuel", k), fuel_f, (k < 4) ? 2 : ((k < 8) ? 1 : 0));
         check($sformatf("fuel.f%0d.phase", k), phase_f, (k < 9) ? 2 : 4);
         $display("fuel frame %0d: phase=%0d fuel=%0d", k, phase_f, fuel_f);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
